// File: rtl/memory_stage.sv
// Memory (M) pipeline stage: issues RV32I loads/stores on a req/ack data bus,
// stalls execute while an access is outstanding, and registers the
// completed instruction with aligned load data for writeback.
module memory_stage #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_x,
  input  logic [31:0] PC_x,
  input  logic [31:0] inst_x,
  input  logic [31:0] alu_x,
  input  logic [31:0] rs2_x,
  output logic        stall_x,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_m,
  output logic [31:0] PC_m,
  output logic [31:0] inst_m,
  output logic [31:0] alu_m,
  output logic [31:0] load_m,
  output logic [1:0]  exc_m
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [6:0]       OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       OP_STORE = 7'b0100011;
  localparam bit               TO_EN    = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             stall_c;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem;
  logic        illegal, misaligned, mem_go;
  logic        timeout_hit, complete;
  logic [1:0]  pt_exc;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign opcode   = inst_x[6:0];
  assign funct3   = inst_x[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;

  assign illegal = (is_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) ||
                   (is_store && (funct3[2] || funct3 == 3'b011));

  assign misaligned = is_mem &&
                      ((funct3[1:0] == 2'b10 && alu_x[1:0] != 2'b00) ||
                       (funct3[1:0] == 2'b01 && alu_x[0]));

  assign mem_go = valid_x && is_mem && !illegal && !misaligned;

  // Exception code for instructions that bypass the bus; illegal outranks misaligned.
  assign pt_exc = !valid_x   ? 2'b00 :
                  illegal    ? 2'b11 :
                  misaligned ? 2'b01 : 2'b00;

  assign timeout_hit = TO_EN && (cnt == CNT_LAST);
  assign complete    = (state == ACCESS) && (dmem_ack || timeout_hit);

  // A held-in-reset stage never asks execute to wait.
  assign stall_x = rst_n && stall_c;

  // Store byte lanes and lane-replicated write data; loads read the full word.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << alu_x[1:0];
          wdata_nxt = {4{rs2_x[7:0]}};
        end
        2'b01: begin
          be_nxt    = alu_x[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{rs2_x[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = rs2_x;
        end
      endcase
    end
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    ld_byte   = dmem_rdata[7:0];
    ld_half   = alu_x[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (alu_x[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'b0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'b0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state and stall: stall while launching an access and until it completes.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_go) begin
          state_nxt = ACCESS;
          stall_c   = 1'b1;
        end
      end
      ACCESS: begin
        if (complete) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and access-age counter (restarts every time we sit in IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

  // Bus request registers: loaded on launch, held until completion drops req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else if (state == IDLE && mem_go) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store;
      dmem_addr  <= {alu_x[31:2], 2'b00};
      dmem_be    <= be_nxt;
      dmem_wdata <= wdata_nxt;
    end else if (complete) begin
      dmem_req <= 1'b0;
    end
  end

  // M pipeline register: pass-through, completed access, or bubble while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m <= 1'b0;
      PC_m    <= '0;
      inst_m  <= '0;
      alu_m   <= '0;
      load_m  <= '0;
      exc_m   <= 2'b00;
    end else if (state == IDLE && !mem_go) begin
      valid_m <= valid_x;
      PC_m    <= PC_x;
      inst_m  <= inst_x;
      alu_m   <= alu_x;
      load_m  <= '0;
      exc_m   <= pt_exc;
    end else if (complete) begin
      valid_m <= 1'b1;
      PC_m    <= PC_x;
      inst_m  <= inst_x;
      alu_m   <= alu_x;
      load_m  <= (dmem_ack && is_load) ? load_data : '0;
      exc_m   <= dmem_ack ? 2'b00 : 2'b10;
    end else begin
      valid_m <= 1'b0;
      load_m  <= '0;
      exc_m   <= 2'b00;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases then randomized
// instruction mix against a byte-arithmetic reference model.
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_x;
  logic [31:0] PC_x, inst_x, alu_x, rs2_x;
  logic        stall_x;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_m;
  logic [31:0] PC_m, inst_m, alu_m, load_m;
  logic [1:0]  exc_m;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit        access;
    bit        isStore;
    bit [1:0]  exc;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit [31:0] load;
  } exp_t;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_x    (valid_x),
    .PC_x       (PC_x),
    .inst_x     (inst_x),
    .alu_x      (alu_x),
    .rs2_x      (rs2_x),
    .stall_x    (stall_x),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .valid_m    (valid_m),
    .PC_m       (PC_m),
    .inst_m     (inst_m),
    .alu_m      (alu_m),
    .load_m     (load_m),
    .exc_m      (exc_m)
  );

  // Expected behaviour derived from the instruction's size/sign rules using plain arithmetic.
  function automatic exp_t refModel(input bit v, input bit [31:0] inst, input bit [31:0] addr,
                                    input bit [31:0] rs2, input bit [31:0] rdata);
    exp_t r;
    int op, f3, size, off;
    bit isLd, isSt, ill, mis;
    longint raw;
    op   = int'(inst[6:0]);
    f3   = int'(inst[14:12]);
    size = 1 << (f3 % 4);
    off  = int'(addr % 4);
    isLd = v && (op == 3);
    isSt = v && (op == 35);
    ill  = (isLd && (f3 == 3 || f3 >= 6)) || (isSt && f3 >= 3);
    mis  = (isLd || isSt) && ((addr % size) != 0);
    r.exc     = ill ? 2'd3 : (mis ? 2'd1 : 2'd0);
    r.access  = (isLd || isSt) && !ill && !mis;
    r.isStore = isSt;
    r.be      = isSt ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1)      r.wdata = 32'(rs2 % 256) * 32'h01010101;
    else if (size == 2) r.wdata = 32'(rs2 % 65536) * 32'h00010001;
    else                r.wdata = rs2;
    r.load = 32'd0;
    if (isLd && r.access) begin
      raw = longint'(rdata) >> (8 * off);
      if (size < 4) begin
        raw = raw % (longint'(1) << (8 * size));
        if (f3 < 4 && raw >= (longint'(1) << (8 * size - 1)))
          raw = raw - (longint'(1) << (8 * size));
      end
      r.load = 32'(raw);
    end
    return r;
  endfunction

  function automatic logic [31:0] mkInst(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = op;
    w[14:12] = f3;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] alu, input logic [31:0] rs2);
    @(posedge clk);
    #1;
    valid_x    = v;
    PC_x       = pc;
    inst_x     = inst;
    alu_x      = alu;
    rs2_x      = rs2;
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
  endtask

  // One instruction end to end: issue cycle, any ACCESS cycles, then the M-register result.
  // ackDelay = ACCESS cycle index carrying the ack, or -1 for no ack.
  task automatic doOp(input string name, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] addr, input logic [31:0] rs2, input int ackDelay,
                      input logic [31:0] rdata);
    exp_t e;
    bit gotAck;
    bit ackNow;
    bit last;
    e      = refModel(v, inst, addr, rs2, rdata);
    gotAck = 1'b0;
    applyStimulus(v, pc, inst, addr, rs2);
    @(negedge clk);
    checkOutput({name, "_issue_stall"}, 32'(stall_x), 32'(e.access));
    checkOutput({name, "_issue_req"}, 32'(dmem_req), 32'd0);
    if (e.access) begin
      for (int k = 0; k < TO; k++) begin
        ackNow = (k == ackDelay);
        last   = ackNow || (k == TO - 1);
        @(posedge clk);
        #1;
        dmem_ack   = ackNow;
        dmem_rdata = ackNow ? rdata : $urandom;
        @(negedge clk);
        checkOutput({name, "_req"}, 32'(dmem_req), 32'd1);
        checkOutput({name, "_we"}, 32'(dmem_we), 32'(e.isStore));
        checkOutput({name, "_addr"}, dmem_addr, addr & ~32'd3);
        checkOutput({name, "_be"}, 32'(dmem_be), 32'(e.be));
        if (e.isStore) checkOutput({name, "_wdata"}, dmem_wdata, e.wdata);
        checkOutput({name, "_bubble"}, 32'(valid_m), 32'd0);
        checkOutput({name, "_acc_stall"}, 32'(stall_x), 32'(!last));
        if (last) begin
          gotAck = ackNow;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    valid_x    = 1'b0;
    PC_x       = $urandom;
    inst_x     = $urandom;
    alu_x      = $urandom;
    dmem_ack   = e.access && !gotAck;
    dmem_rdata = $urandom;
    @(negedge clk);
    checkOutput({name, "_valid_m"}, 32'(valid_m), 32'(v));
    checkOutput({name, "_exc_m"}, 32'(exc_m), e.access ? (gotAck ? 32'd0 : 32'd2) : 32'(e.exc));
    checkOutput({name, "_load_m"}, load_m, (e.access && gotAck) ? e.load : 32'd0);
    checkOutput({name, "_pc_m"}, PC_m, pc);
    checkOutput({name, "_inst_m"}, inst_m, inst);
    checkOutput({name, "_alu_m"}, alu_m, addr);
    checkOutput({name, "_done_req"}, 32'(dmem_req), 32'd0);
    checkOutput({name, "_done_stall"}, 32'(stall_x), 32'd0);
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;

    rst_n      = 1'b0;
    valid_x    = 1'b0;
    PC_x       = '0;
    inst_x     = '0;
    alu_x      = '0;
    rs2_x      = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;

    #12;
    checkOutput("rst_valid_m", 32'(valid_m), 32'd0);
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_stall", 32'(stall_x), 32'd0);
    checkOutput("rst_exc_m", 32'(exc_m), 32'd0);
    checkOutput("rst_load_m", load_m, 32'd0);
    checkOutput("rst_pc_m", PC_m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    doOp("alu", 1'b1, 32'h0000_0040, 32'h0020_81B3, 32'h0000_1234, 32'h0, -1, 32'h0);
    doOp("lb", 1'b1, 32'h0000_0044, mkInst(7'b0000011, 3'b000), 32'h0000_0103, 32'h0, 2, 32'h80AA_BBCC);
    checkOutput("lb_spec_value", load_m, 32'hFFFF_FF80);
    doOp("sh", 1'b1, 32'h0000_0048, mkInst(7'b0100011, 3'b001), 32'h0000_0202, 32'hDEAD_BEEF, 0, 32'h0);
    doOp("lw_mis", 1'b1, 32'h0000_004C, mkInst(7'b0000011, 3'b010), 32'h0000_0101, 32'h0, 0, 32'h0);
    doOp("ld_illegal", 1'b1, 32'h0000_0050, mkInst(7'b0000011, 3'b110), 32'h0000_0100, 32'h0, 0, 32'h0);
    doOp("st_illegal", 1'b1, 32'h0000_0054, mkInst(7'b0100011, 3'b011), 32'h0000_0101, 32'h0, 0, 32'h0);
    doOp("timeout", 1'b1, 32'h0000_0058, mkInst(7'b0000011, 3'b010), 32'h0000_0300, 32'h0, -1, 32'h0);
    doOp("after_late_ack", 1'b1, 32'h0000_005C, 32'h0020_81B3, 32'h0000_0077, 32'h0, -1, 32'h0);
    doOp("ack_vs_to", 1'b1, 32'h0000_0060, mkInst(7'b0000011, 3'b101), 32'h0000_0402, 32'h0, TO - 1, 32'h8765_4321);
    doOp("sb", 1'b1, 32'h0000_0064, mkInst(7'b0100011, 3'b000), 32'h0000_0503, 32'h1234_56A5, 1, 32'h0);

    $display("[TB] reset during access");
    applyStimulus(1'b1, 32'h0000_0068, mkInst(7'b0000011, 3'b010), 32'h0000_0600, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstacc_req_before", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstacc_req", 32'(dmem_req), 32'd0);
    checkOutput("rstacc_stall", 32'(stall_x), 32'd0);
    checkOutput("rstacc_valid_m", 32'(valid_m), 32'd0);
    valid_x = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstacc_idle_req", 32'(dmem_req), 32'd0);
    checkOutput("rstacc_idle_stall", 32'(stall_x), 32'd0);
    doOp("post_rst_lw", 1'b1, 32'h0000_006C, mkInst(7'b0000011, 3'b010), 32'h0000_0700, 32'h0, 1, 32'hCAFE_F00D);

    $display("[TB] randomized instruction mix");
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      op   = (kind == 0) ? 7'b0110011 : ((kind == 2) ? 7'b0100011 : 7'b0000011);
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) f3 = (op == 7'b0100011) ? 3'($urandom_range(0, 2)) : 3'(f3 & 3'b101);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      doOp("rnd", ($urandom_range(0, 9) != 0), $urandom, mkInst(op, f3), a, $urandom,
           $urandom_range(0, 4) - 1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
